// File: rtl/bp_pkg.sv
// -----------------------------------------------------------------------------
// bp_pkg
// Shared types and helpers for the dynamic branch predictor.
//   ctr_t      : 2-bit saturating counter states (SNT/WNT/WT/ST)
//   CTR_RESET  : counter value every entry takes on reset (weakly not-taken)
//   CTR_ALLOC  : counter value of a freshly allocated entry (weakly taken)
//   ctr_next() : saturating increment on taken, decrement on not-taken
// -----------------------------------------------------------------------------
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    localparam ctr_t CTR_RESET = WNT;
    localparam ctr_t CTR_ALLOC = WT;

    function automatic ctr_t ctr_next(ctr_t cur, logic taken);
        ctr_t nxt;
        nxt = cur;
        if (taken) begin
            if (cur != ST) nxt = ctr_t'(cur + 2'd1);
        end else begin
            if (cur != SNT) nxt = ctr_t'(cur - 2'd1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// -----------------------------------------------------------------------------
// branch_predictor_if
// Bundles the fetch-side lookup and execute-side resolve signals of the
// branch predictor.
//   slave  modport : the predictor (receives PCs/outcomes, drives predictions)
//   master modport : the pipeline  (drives PCs/outcomes, receives predictions)
// Fetch  : i_pc_F -> o_pred_taken_F, o_pred_pc_F
// Execute: i_pc_E, i_is_br_E, i_br_taken_E, i_br_target_E, i_pred_taken_E,
//          i_pred_pc_E -> o_mispredict, o_redirect_pc
// Optional (BP_STATS_EN): o_br_cnt, o_miss_cnt statistics counters.
// -----------------------------------------------------------------------------
interface branch_predictor_if #(
    parameter int PC_W = 32
);
    logic [PC_W-1:0] i_pc_F;
    logic            o_pred_taken_F;
    logic [PC_W-1:0] o_pred_pc_F;

    logic [PC_W-1:0] i_pc_E;
    logic            i_is_br_E;
    logic            i_br_taken_E;
    logic [PC_W-1:0] i_br_target_E;
    logic            i_pred_taken_E;
    logic [PC_W-1:0] i_pred_pc_E;
    logic            o_mispredict;
    logic [PC_W-1:0] o_redirect_pc;

`ifdef BP_STATS_EN
    logic [31:0]     o_br_cnt;
    logic [31:0]     o_miss_cnt;
`endif

    modport slave (
        input  i_pc_F,
        output o_pred_taken_F,
        output o_pred_pc_F,
        input  i_pc_E,
        input  i_is_br_E,
        input  i_br_taken_E,
        input  i_br_target_E,
        input  i_pred_taken_E,
        input  i_pred_pc_E,
        output o_mispredict,
        output o_redirect_pc
`ifdef BP_STATS_EN
        , output o_br_cnt
        , output o_miss_cnt
`endif
    );

    modport master (
        output i_pc_F,
        input  o_pred_taken_F,
        input  o_pred_pc_F,
        output i_pc_E,
        output i_is_br_E,
        output i_br_taken_E,
        output i_br_target_E,
        output i_pred_taken_E,
        output i_pred_pc_E,
        input  o_mispredict,
        input  o_redirect_pc
`ifdef BP_STATS_EN
        , input o_br_cnt
        , input o_miss_cnt
`endif
    );

endinterface

// File: rtl/bp_btb.sv
// -----------------------------------------------------------------------------
// bp_btb
// Direct-mapped branch target buffer with 2-bit counters.
//   i_clk, i_rst       : clock, asynchronous active-high reset (clears valid
//                        and counters only)
//   rd_idx             : combinational read index (fetch lookup)
//   rd_valid/rd_tag/rd_target/rd_ctr : contents of the addressed entry
//   upd_en             : apply one resolved branch on the next rising edge
//   upd_idx/upd_tag    : entry index and tag of the resolving branch
//   upd_taken          : resolved direction
//   upd_target         : resolved target
// Hit entries train their counter (target refreshed when taken); taken misses
// allocate; not-taken misses leave the table untouched. A same-cycle read of
// the written index returns the pre-write contents.
// -----------------------------------------------------------------------------
module bp_btb
    import bp_pkg::*;
#(
    parameter int INDEX_W = 6,
    parameter int PC_W    = 32,
    parameter int TAG_W   = PC_W - INDEX_W - 2
) (
    input  logic               i_clk,
    input  logic               i_rst,

    input  logic [INDEX_W-1:0] rd_idx,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [PC_W-1:0]    rd_target,
    output ctr_t               rd_ctr,

    input  logic               upd_en,
    input  logic [INDEX_W-1:0] upd_idx,
    input  logic [TAG_W-1:0]   upd_tag,
    input  logic               upd_taken,
    input  logic [PC_W-1:0]    upd_target
);

    localparam int DEPTH = 2 ** INDEX_W;

    logic            valid      [DEPTH];
    ctr_t            ctr        [DEPTH];
    logic [TAG_W-1:0] tag_mem   [DEPTH];
    logic [PC_W-1:0] target_mem [DEPTH];

    logic upd_hit;

    assign rd_valid  = valid[rd_idx];
    assign rd_tag    = tag_mem[rd_idx];
    assign rd_target = target_mem[rd_idx];
    assign rd_ctr    = ctr[rd_idx];

    // valid gates the compare so never-written tags cannot produce a hit
    assign upd_hit = valid[upd_idx] && (tag_mem[upd_idx] == upd_tag);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; this is also what gives the fetch port its
    // pre-write view of an entry being updated in the same cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid[i] <= 1'b0;
                ctr[i]   <= CTR_RESET;
            end
        end else if (upd_en) begin
            if (upd_hit) begin
                ctr[upd_idx] <= ctr_next(ctr[upd_idx], upd_taken);
            end else if (upd_taken) begin
                valid[upd_idx] <= 1'b1;
                ctr[upd_idx]   <= CTR_ALLOC;
            end
        end
    end

    // NOTE: tag and target storage is deliberately not reset; the cleared
    // valid bits make its contents irrelevant, and leaving it reset-free lets
    // it map onto plain RAM.
    always_ff @(posedge i_clk) begin
        // Taken covers both a hit (target refresh, tag unchanged) and an
        // allocation on a miss.
        if (upd_en && upd_taken) begin
            tag_mem[upd_idx]    <= upd_tag;
            target_mem[upd_idx] <= upd_target;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
// Dynamic branch predictor beside Fetch/Execute, upstream of the hazard unit.
//   i_clk : clock, state updates on rising edge
//   i_rst : asynchronous active-high reset (all entries invalid, counters WNT)
//   bp    : branch_predictor_if.slave
//     Fetch  : i_pc_F -> o_pred_taken_F, o_pred_pc_F (combinational)
//     Execute: resolved outcome vs. piped prediction -> o_mispredict,
//              o_redirect_pc (combinational); table trained on i_is_br_E
// Optional feature macro BP_STATS_EN: adds o_br_cnt (branches resolved) and
// o_miss_cnt (mispredict cycles), 32-bit wrapping, cleared by i_rst.
// -----------------------------------------------------------------------------
module branch_predictor
    import bp_pkg::*;
#(
    parameter int INDEX_W = 6,
    parameter int PC_W    = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    branch_predictor_if.slave bp
);

    localparam int              TAG_W  = PC_W - INDEX_W - 2;
    localparam logic [PC_W-1:0] PC_INC = PC_W'(4);

    // Index/tag split: word-aligned PCs, low two bits unused for indexing.
    logic [INDEX_W-1:0] f_idx;
    logic [TAG_W-1:0]   f_tag;
    logic [INDEX_W-1:0] e_idx;
    logic [TAG_W-1:0]   e_tag;

    assign f_idx = bp.i_pc_F[INDEX_W+1:2];
    assign f_tag = bp.i_pc_F[PC_W-1:INDEX_W+2];
    assign e_idx = bp.i_pc_E[INDEX_W+1:2];
    assign e_tag = bp.i_pc_E[PC_W-1:INDEX_W+2];

    logic            rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [PC_W-1:0] rd_target;
    ctr_t            rd_ctr;

    bp_btb #(
        .INDEX_W (INDEX_W),
        .PC_W    (PC_W),
        .TAG_W   (TAG_W)
    ) u_btb (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .rd_idx     (f_idx),
        .rd_valid   (rd_valid),
        .rd_tag     (rd_tag),
        .rd_target  (rd_target),
        .rd_ctr     (rd_ctr),
        .upd_en     (bp.i_is_br_E),
        .upd_idx    (e_idx),
        .upd_tag    (e_tag),
        .upd_taken  (bp.i_br_taken_E),
        .upd_target (bp.i_br_target_E)
    );

    // ------------------------------------------------------------------
    // Fetch lookup
    // ------------------------------------------------------------------
    logic            f_hit;
    logic            pred_taken;
    logic [PC_W-1:0] pred_pc;

    assign f_hit = rd_valid && (rd_tag == f_tag);

    // NOTE: every always_comb output gets a default before any condition so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        pred_taken = 1'b0;
        pred_pc    = bp.i_pc_F + PC_INC;
        if (f_hit && rd_ctr[1]) begin
            pred_taken = 1'b1;
            pred_pc    = rd_target;
        end
    end

    assign bp.o_pred_taken_F = pred_taken;
    assign bp.o_pred_pc_F    = pred_pc;

    // ------------------------------------------------------------------
    // Execute resolve / redirect
    // ------------------------------------------------------------------
    logic mispredict;

    // A taken prediction on a non-branch (bubble or aliased PC) sent fetch
    // down a bogus path, so it is a mispredict as well.
    always_comb begin
        mispredict = bp.i_pred_taken_E;
        if (bp.i_is_br_E) begin
            mispredict = (bp.i_br_taken_E != bp.i_pred_taken_E) ||
                         (bp.i_br_taken_E && (bp.i_br_target_E != bp.i_pred_pc_E));
        end
    end

    assign bp.o_mispredict  = mispredict;
    assign bp.o_redirect_pc = (bp.i_is_br_E && bp.i_br_taken_E) ? bp.i_br_target_E
                                                                : bp.i_pc_E + PC_INC;

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
`ifdef BP_STATS_EN
    logic [31:0] br_cnt;
    logic [31:0] miss_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            br_cnt   <= '0;
            miss_cnt <= '0;
        end else begin
            if (bp.i_is_br_E) br_cnt   <= br_cnt + 32'd1;
            if (mispredict)   miss_cnt <= miss_cnt + 32'd1;
        end
    end

    assign bp.o_br_cnt   = br_cnt;
    assign bp.o_miss_cnt = miss_cnt;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
// Self-checking bench for branch_predictor (INDEX_W=6, PC_W=32). Each cycle
// row drives fetch and execute inputs together; its expected outputs go into
// a scoreboard queue and are popped and compared on the falling edge, before
// the rising edge that commits the execute-stage update.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_branch_predictor;
    import bp_pkg::*;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;

    always #5 i_clk = ~i_clk;

    branch_predictor_if #(.PC_W(32)) bp_if ();

    branch_predictor #(.INDEX_W(6), .PC_W(32)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bp    (bp_if)
    );

    typedef struct {
        logic [31:0] pc_f;
        logic        is_br;
        logic        taken;
        logic [31:0] pc_e;
        logic [31:0] tgt_e;
        logic        pt_e;
        logic [31:0] pp_e;
        logic        x_pt;
        logic [31:0] x_pp;
        logic        x_mis;
        logic [31:0] x_rd;
    } row_t;

    typedef struct {
        logic        pt;
        logic [31:0] pp;
        logic        mis;
        logic [31:0] rd;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic row_t mk(logic [31:0] pc_f, logic is_br, logic taken,
                                logic [31:0] pc_e, logic [31:0] tgt_e,
                                logic pt_e, logic [31:0] pp_e,
                                logic x_pt, logic [31:0] x_pp,
                                logic x_mis, logic [31:0] x_rd);
        row_t r;
        r.pc_f = pc_f;  r.is_br = is_br; r.taken = taken;
        r.pc_e = pc_e;  r.tgt_e = tgt_e; r.pt_e = pt_e;  r.pp_e = pp_e;
        r.x_pt = x_pt;  r.x_pp = x_pp;   r.x_mis = x_mis; r.x_rd = x_rd;
        return r;
    endfunction

    // Idle execute stage: bubble at pc_e=0, so redirect reads 0+4.
    function automatic row_t idle(logic [31:0] pc_f, logic x_pt, logic [31:0] x_pp);
        return mk(pc_f, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                  x_pt, x_pp, 1'b0, 32'h4);
    endfunction

    task automatic drive(input row_t r);
        exp_t e;
        bp_if.i_pc_F         = r.pc_f;
        bp_if.i_is_br_E      = r.is_br;
        bp_if.i_br_taken_E   = r.taken;
        bp_if.i_pc_E         = r.pc_e;
        bp_if.i_br_target_E  = r.tgt_e;
        bp_if.i_pred_taken_E = r.pt_e;
        bp_if.i_pred_pc_E    = r.pp_e;
        e.pt = r.x_pt; e.pp = r.x_pp; e.mis = r.x_mis; e.rd = r.x_rd;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        drive(idle(32'h100, 1'b0, 32'h104));
        #1;
        e = exp_q.pop_front();
        n_cmp++;
        if ({bp_if.o_pred_taken_F, bp_if.o_pred_pc_F, bp_if.o_mispredict, bp_if.o_redirect_pc}
            !== {e.pt, e.pp, e.mis, e.rd}) begin
            n_bad++;
            $display("FAIL reset_lookup: got pt=%b pp=%h mis=%b rd=%h, want pt=%b pp=%h mis=%b rd=%h",
                     bp_if.o_pred_taken_F, bp_if.o_pred_pc_F, bp_if.o_mispredict,
                     bp_if.o_redirect_pc, e.pt, e.pp, e.mis, e.rd);
        end
`ifdef BP_STATS_EN
        n_cmp++;
        if ({bp_if.o_br_cnt, bp_if.o_miss_cnt} !== 64'h0) begin
            n_bad++;
            $display("FAIL reset_stats: got br=%0d miss=%0d, want 0/0",
                     bp_if.o_br_cnt, bp_if.o_miss_cnt);
        end
`endif
        @(posedge i_clk); #1;
        i_rst = 1'b0;
    endtask

    // Rows: scenario 2 (allocate on taken miss) then scenario 3 (counter
    // training down to SNT, saturation, and back up to WT).
    task automatic test_train();
        row_t rows[$];
        exp_t e;
        rows = {
            mk(32'h100, 1, 1, 32'h100, 32'h40, 0, 32'h104, 0, 32'h104, 1, 32'h40),
            idle(32'h100, 1'b1, 32'h40),
            mk(32'h100, 1, 0, 32'h100, 32'h0,  1, 32'h40,  1, 32'h40,  1, 32'h104),
            mk(32'h100, 1, 0, 32'h100, 32'h0,  0, 32'h104, 0, 32'h104, 0, 32'h104),
            mk(32'h100, 1, 0, 32'h100, 32'h0,  0, 32'h104, 0, 32'h104, 0, 32'h104),
            mk(32'h100, 1, 1, 32'h100, 32'h40, 0, 32'h104, 0, 32'h104, 1, 32'h40),
            mk(32'h100, 1, 1, 32'h100, 32'h40, 0, 32'h104, 0, 32'h104, 1, 32'h40),
            idle(32'h100, 1'b1, 32'h40)
        };
        foreach (rows[i]) begin
            drive(rows[i]);
            @(negedge i_clk);
            e = exp_q.pop_front();
            n_cmp++;
            if ({bp_if.o_pred_taken_F, bp_if.o_pred_pc_F, bp_if.o_mispredict, bp_if.o_redirect_pc}
                !== {e.pt, e.pp, e.mis, e.rd}) begin
                n_bad++;
                $display("FAIL train[%0d]: got pt=%b pp=%h mis=%b rd=%h, want pt=%b pp=%h mis=%b rd=%h",
                         i, bp_if.o_pred_taken_F, bp_if.o_pred_pc_F, bp_if.o_mispredict,
                         bp_if.o_redirect_pc, e.pt, e.pp, e.mis, e.rd);
            end
            @(posedge i_clk); #1;
        end
    endtask

    // Entry at 0x100 is WT/0x40: taken to a new target, saturate at ST, then
    // one not-taken still predicts taken.
    task automatic test_target();
        row_t rows[$];
        exp_t e;
        rows = {
            mk(32'h100, 1, 1, 32'h100, 32'h80, 1, 32'h40, 1, 32'h40, 1, 32'h80),
            mk(32'h100, 1, 1, 32'h100, 32'h80, 1, 32'h80, 1, 32'h80, 0, 32'h80),
            mk(32'h100, 1, 0, 32'h100, 32'h0,  1, 32'h80, 1, 32'h80, 1, 32'h104),
            idle(32'h100, 1'b1, 32'h80)
        };
        foreach (rows[i]) begin
            drive(rows[i]);
            @(negedge i_clk);
            e = exp_q.pop_front();
            n_cmp++;
            if ({bp_if.o_pred_taken_F, bp_if.o_pred_pc_F, bp_if.o_mispredict, bp_if.o_redirect_pc}
                !== {e.pt, e.pp, e.mis, e.rd}) begin
                n_bad++;
                $display("FAIL target[%0d]: got pt=%b pp=%h mis=%b rd=%h, want pt=%b pp=%h mis=%b rd=%h",
                         i, bp_if.o_pred_taken_F, bp_if.o_pred_pc_F, bp_if.o_mispredict,
                         bp_if.o_redirect_pc, e.pt, e.pp, e.mis, e.rd);
            end
            @(posedge i_clk); #1;
        end
    endtask

    // 0x200 aliases 0x100 (index 0): taken replaces, not-taken miss is inert.
    task automatic test_alias();
        row_t rows[$];
        exp_t e;
        rows = {
            mk(32'h200, 1, 1, 32'h200, 32'h300, 0, 32'h204, 0, 32'h204, 1, 32'h300),
            idle(32'h100, 1'b0, 32'h104),
            idle(32'h200, 1'b1, 32'h300),
            mk(32'h200, 1, 0, 32'h100, 32'h0,   0, 32'h104, 1, 32'h300, 0, 32'h104),
            idle(32'h200, 1'b1, 32'h300)
        };
        foreach (rows[i]) begin
            drive(rows[i]);
            @(negedge i_clk);
            e = exp_q.pop_front();
            n_cmp++;
            if ({bp_if.o_pred_taken_F, bp_if.o_pred_pc_F, bp_if.o_mispredict, bp_if.o_redirect_pc}
                !== {e.pt, e.pp, e.mis, e.rd}) begin
                n_bad++;
                $display("FAIL alias[%0d]: got pt=%b pp=%h mis=%b rd=%h, want pt=%b pp=%h mis=%b rd=%h",
                         i, bp_if.o_pred_taken_F, bp_if.o_pred_pc_F, bp_if.o_mispredict,
                         bp_if.o_redirect_pc, e.pt, e.pp, e.mis, e.rd);
            end
            @(posedge i_clk); #1;
        end
    endtask

    // Consecutive allocations at different indices, non-branch with a stale
    // taken prediction, and PC+4 wrap at the top of the address space.
    task automatic test_back_to_back();
        row_t rows[$];
        exp_t e;
        rows = {
            mk(32'h1004, 1, 1, 32'h1004, 32'h2000, 0, 32'h1008, 0, 32'h1008, 1, 32'h2000),
            mk(32'h1004, 1, 1, 32'h1008, 32'h3000, 0, 32'h100c, 1, 32'h2000, 1, 32'h3000),
            mk(32'h1008, 0, 0, 32'h500,  32'h0,    1, 32'h600,  1, 32'h3000, 1, 32'h504),
            mk(32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0)
        };
        foreach (rows[i]) begin
            drive(rows[i]);
            @(negedge i_clk);
            e = exp_q.pop_front();
            n_cmp++;
            if ({bp_if.o_pred_taken_F, bp_if.o_pred_pc_F, bp_if.o_mispredict, bp_if.o_redirect_pc}
                !== {e.pt, e.pp, e.mis, e.rd}) begin
                n_bad++;
                $display("FAIL b2b[%0d]: got pt=%b pp=%h mis=%b rd=%h, want pt=%b pp=%h mis=%b rd=%h",
                         i, bp_if.o_pred_taken_F, bp_if.o_pred_pc_F, bp_if.o_mispredict,
                         bp_if.o_redirect_pc, e.pt, e.pp, e.mis, e.rd);
            end
            @(posedge i_clk); #1;
        end
    endtask

    // Fresh reset, 3 branches / 2 mispredicts, then reset asserted between
    // edges: the entry must vanish immediately and the counters clear.
    task automatic test_async_reset();
        row_t rows[$];
        exp_t e;
        i_rst = 1'b1; #2; i_rst = 1'b0;
        rows = {
            mk(32'h100, 1, 1, 32'h100, 32'h40, 0, 32'h104, 0, 32'h104, 1, 32'h40),
            mk(32'h100, 1, 1, 32'h100, 32'h40, 1, 32'h40,  1, 32'h40,  0, 32'h40),
            mk(32'h100, 1, 0, 32'h100, 32'h0,  1, 32'h40,  1, 32'h40,  1, 32'h104),
            idle(32'h100, 1'b1, 32'h40)
        };
        foreach (rows[i]) begin
            drive(rows[i]);
            @(negedge i_clk);
            e = exp_q.pop_front();
            n_cmp++;
            if ({bp_if.o_pred_taken_F, bp_if.o_pred_pc_F, bp_if.o_mispredict, bp_if.o_redirect_pc}
                !== {e.pt, e.pp, e.mis, e.rd}) begin
                n_bad++;
                $display("FAIL arst[%0d]: got pt=%b pp=%h mis=%b rd=%h, want pt=%b pp=%h mis=%b rd=%h",
                         i, bp_if.o_pred_taken_F, bp_if.o_pred_pc_F, bp_if.o_mispredict,
                         bp_if.o_redirect_pc, e.pt, e.pp, e.mis, e.rd);
            end
            if (i != rows.size() - 1) begin
                @(posedge i_clk); #1;
            end
        end
`ifdef BP_STATS_EN
        n_cmp++;
        if (bp_if.o_br_cnt !== 32'd3 || bp_if.o_miss_cnt !== 32'd2) begin
            n_bad++;
            $display("FAIL stats_count: got br=%0d miss=%0d, want 3/2",
                     bp_if.o_br_cnt, bp_if.o_miss_cnt);
        end
`endif
        // Mid-cycle (at the falling edge) reset with no rising edge in between.
        i_rst = 1'b1;
        exp_q.push_back('{pt: 1'b0, pp: 32'h104, mis: 1'b0, rd: 32'h4});
        #1;
        e = exp_q.pop_front();
        n_cmp++;
        if ({bp_if.o_pred_taken_F, bp_if.o_pred_pc_F} !== {e.pt, e.pp}) begin
            n_bad++;
            $display("FAIL arst_clear: got pt=%b pp=%h, want pt=%b pp=%h",
                     bp_if.o_pred_taken_F, bp_if.o_pred_pc_F, e.pt, e.pp);
        end
`ifdef BP_STATS_EN
        n_cmp++;
        if ({bp_if.o_br_cnt, bp_if.o_miss_cnt} !== 64'h0) begin
            n_bad++;
            $display("FAIL stats_clear: got br=%0d miss=%0d, want 0/0",
                     bp_if.o_br_cnt, bp_if.o_miss_cnt);
        end
`endif
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        drive(idle(32'h100, 1'b0, 32'h104));
        @(negedge i_clk);
        e = exp_q.pop_front();
        n_cmp++;
        if ({bp_if.o_pred_taken_F, bp_if.o_pred_pc_F, bp_if.o_mispredict, bp_if.o_redirect_pc}
            !== {e.pt, e.pp, e.mis, e.rd}) begin
            n_bad++;
            $display("FAIL arst_after: got pt=%b pp=%h mis=%b rd=%h, want pt=%b pp=%h mis=%b rd=%h",
                     bp_if.o_pred_taken_F, bp_if.o_pred_pc_F, bp_if.o_mispredict,
                     bp_if.o_redirect_pc, e.pt, e.pp, e.mis, e.rd);
        end
        @(posedge i_clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_train();
        test_target();
        test_alias();
        test_back_to_back();
        test_async_reset();
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
